// File: rtl/uart_pkg.sv
// Shared UART framing definitions: state encoding, parity selectors, line levels.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Turn the XOR of the data bits into the parity bit for the selected mode.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        case (par_typ)
            PAR_EVEN: parity_bit = data_xor;
            PAR_ODD:  parity_bit = ~data_xor;
            default:  parity_bit = data_xor;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side of the UART transmitter plus its serial/busy outputs.
// Latency: n/a (signal bundle).
// Backpressure: Busy tells the requester when a strobe would be dropped.
interface uart_tx_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_En;
    logic                  Par_Typ;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output Par_En,
        output Par_Typ,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  Par_En,
        input  Par_Typ,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Data-bit shifter: loads a word, shifts it out LSB first, flags the last bit.
// Latency: next_bit is the bit the line shows in the cycle after the current edge.
// Backpressure: none; load and shift are driven by the frame FSM.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_dat,
    input  logic                  shift,
    output logic                  next_bit,
    output logic                  done
);
    localparam int              CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_shr;
    logic [CNT_W-1:0]      cnt;

    assign shreg_shr = shreg >> 1;

    // Load a fresh word on acceptance, otherwise shift one bit per data cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_dat;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= shreg_shr;
            cnt   <= cnt + 1'b1;
        end
    end

    // While shifting, the bit shown next is the one about to slide into position 0.
    assign next_bit = shift ? shreg_shr[0] : shreg[0];
    assign done     = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, data LSB first, optional parity, one stop bit, one bit per clk.
// Latency: start bit and Busy appear in the cycle after the accepting edge.
// Backpressure: strobes are taken only in IDLE or the stop cycle; all others are dropped.
module uart_tx #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
    input logic      clk,
    input logic      rst_n,
    uart_tx_if.slave bus
);
    import uart_pkg::*;

    uart_state_t state;
    uart_state_t state_nxt;

    logic accept;
    logic shift;
    logic ser_next_bit;
    logic ser_done;
    logic par_en_q;
    logic par_typ_q;
    logic data_xor_q;
    logic tx_q;
    logic tx_nxt;
    logic busy_q;
    logic busy_nxt;

    // The stop cycle may also take a request so frames can run back to back.
    assign accept = bus.Data_Valid && ((state == IDLE) || (state == STOP));

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_dat (bus.P_DATA),
        .shift    (shift),
        .next_bit (ser_next_bit),
        .done     (ser_done)
    );

    // Frame sequencing and the registered line value for the next cycle.
    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        tx_nxt    = LINE_IDLE;

        case (state)
            IDLE:   if (accept) state_nxt = START;
            START:  state_nxt = DATA;
            DATA: begin
                shift = 1'b1;
                if (ser_done) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: state_nxt = STOP;
            STOP:   state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   tx_nxt = START_BIT;
            DATA:    tx_nxt = ser_next_bit;
            PARITY:  tx_nxt = parity_bit(data_xor_q, par_typ_q);
            STOP:    tx_nxt = STOP_BIT;
            default: tx_nxt = LINE_IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, frame options and the output flops; reset drops the line to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            data_xor_q <= 1'b0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            tx_q   <= tx_nxt;
            busy_q <= busy_nxt;
            if (accept) begin
                par_en_q   <= bus.Par_En;
                par_typ_q  <= bus.Par_Typ;
                data_xor_q <= ^bus.P_DATA;
            end
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: driver pushes expected frames, negedge monitor decodes the line.
// Latency: checks start bit and Busy in the cycle after each accepted strobe.
// Backpressure: strobes issued while busy (outside the stop cycle) must vanish.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] dat;
        bit            pe;
        bit            pt;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_if #(.DATA_WIDTH(DW)) bus();

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    frame_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    function automatic int frame_len(input frame_t f);
        return DW + 2 + (f.pe ? 1 : 0);
    endfunction

    // Reference frame: bit i is the line level in the i-th cycle of the frame.
    function automatic logic [31:0] frame_bits(input frame_t f);
        logic [31:0] b;
        int          ones;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1 + i] = f.dat[i];
        if (f.pe) begin
            ones      = $countones(f.dat);
            b[DW + 1] = f.pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return b;
    endfunction

    // Monitor: frames start when Busy rises from idle; each is compared whole.
    initial begin : monitor
        frame_t      cur;
        bit          in_frame;
        bit          busy_ok;
        int          idx;
        int          len;
        logic [31:0] got;
        in_frame = 0;
        busy_ok  = 1;
        idx      = 0;
        len      = 0;
        got      = '1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                check("reset_tx", 32'(bus.TX_OUT), 32'd1);
                check("reset_busy", 32'(bus.Busy), 32'd0);
            end else if (!in_frame) begin
                if (bus.Busy) begin
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        len      = frame_len(cur);
                        got      = '1;
                        got[0]   = bus.TX_OUT;
                        idx      = 1;
                        busy_ok  = 1;
                        in_frame = 1;
                    end
                end else begin
                    check("idle_tx", 32'(bus.TX_OUT), 32'd1);
                end
            end else begin
                got[idx] = bus.TX_OUT;
                if (!bus.Busy) busy_ok = 0;
                idx++;
                if (idx == len) begin
                    check("frame_bits", got, frame_bits(cur));
                    check("frame_busy", 32'(busy_ok), 32'd1);
                    in_frame = 0;
                end
            end
        end
    end

    // Drive one strobe cycle; expected frames are queued and start latency checked.
    task automatic issue(input logic [DW-1:0] d, input bit pe, input bit pt, input bit expect_acc);
        frame_t f;
        bus.P_DATA     = d;
        bus.Par_En     = pe;
        bus.Par_Typ    = pt;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = DW'($urandom);
        bus.Par_En     = 1'($urandom);
        bus.Par_Typ    = 1'($urandom);
        if (expect_acc) begin
            f.dat = d;
            f.pe  = pe;
            f.pt  = pt;
            exp_q.push_back(f);
            check("start_busy", 32'(bus.Busy), 32'd1);
            check("start_tx", 32'(bus.TX_OUT), 32'd0);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt);
        int n;
        n = 0;
        while (bus.Busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_wait_idle", 32'(bus.Busy), 32'd0);
        issue(d, pe, pt, 1'b1);
    endtask

    // Called in the first cycle of a frame of prev_len cycles; strobes in its stop cycle.
    task automatic send_b2b(input int prev_len, input logic [DW-1:0] d, input bit pe, input bit pt);
        repeat (prev_len - 1) begin
            @(posedge clk);
            #1;
        end
        issue(d, pe, pt, 1'b1);
    endtask

    initial begin : watchdog
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got=30000 cycles expected=finish before limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        frame_t f;
        int     last_len;
        int     mode;
        int     k;
        int     n;

        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.Par_En     = 1'b0;
        bus.Par_Typ    = 1'b0;

        #23;
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Parity variants of the same byte.
        send(8'hA5, 1'b1, PAR_EVEN);
        send(8'hA5, 1'b1, PAR_ODD);
        send(8'hA5, 1'b0, PAR_EVEN);

        // Back-to-back frames with no idle gap.
        send(8'hA5, 1'b1, PAR_EVEN);
        send_b2b(11, 8'h3C, 1'b0, PAR_EVEN);

        // A strobe during data bit 2 must be dropped.
        send(8'h00, 1'b0, PAR_EVEN);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(8'hFF, 1'b0, PAR_EVEN, 1'b0);

        // Reset during data bit 4, then a clean frame.
        send(8'h5A, 1'b1, PAR_ODD);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midframe_rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("midframe_rst_busy", 32'(bus.Busy), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h81, 1'b1, PAR_EVEN);

        // Random bytes: 25 each with no parity, even parity, odd parity.
        last_len = 0;
        for (int i = 0; i < 75; i++) begin
            mode  = i / 25;
            f.dat = DW'($urandom);
            f.pe  = (mode != 0);
            f.pt  = (mode == 2);
            if (last_len != 0 && $urandom_range(0, 2) == 0) begin
                send_b2b(last_len, f.dat, f.pe, f.pt);
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                send(f.dat, f.pe, f.pt);
            end
            last_len = frame_len(f);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, last_len - 2);
                repeat (k) begin
                    @(posedge clk);
                    #1;
                end
                issue(DW'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                last_len = 0;
            end
        end

        n = 0;
        while ((bus.Busy || exp_q.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(bus.Busy), 32'd0);
        check("final_tx", 32'(bus.TX_OUT), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the counterpart of the existing UART_RX on the same serial line. It accepts a parallel byte with a one-cycle valid strobe and serialises it as a frame: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity bit, and one stop bit. It runs on the TX bit clock, one bit per clk cycle, so it needs no prescaler. Its output drives the RX_IN of a peer UART_RX.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  TX bit clock; one serial bit per rising edge.
rst_n  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on an accepted strobe.
Data_Valid  input  1  single-cycle request strobe; accepted only when the block is free (see acceptance rule).
Par_En  input  1  1 = parity bit inserted in the frame; sampled with P_DATA.
Par_Typ  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA.
TX_OUT  output  1  serial line; idle level is high.
Busy  output  1  high while a frame is on the line.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: TX_OUT=1, Busy=0, FSM=IDLE. All internal registers (shift register, bit counter, latched Par_En, latched Par_Typ, parity) are cleared to 0.
- Outputs: TX_OUT and Busy are registered. No combinational path from any input to any output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance rule: Data_Valid is accepted on a rising edge when FSM=IDLE, or when FSM=STOP in the final stop cycle (back-to-back frames).
- On acceptance:
  - P_DATA, Par_En and Par_Typ are latched.
  - Parity is computed from the latched data: even = XOR of the data bits; odd = inverse of that XOR.
  - FSM goes to START.
- Latency: TX_OUT=0 and Busy=1 are visible in the cycle immediately after the accepting edge.
- START: one cycle, TX_OUT=0. Next state is DATA with the bit counter at 0.
- DATA:
  - TX_OUT = shift-register bit 0 (data bit index = counter); the register shifts right each cycle.
  - Runs for DATA_WIDTH cycles; the counter goes 0..DATA_WIDTH-1.
  - At the last data bit, next state is PARITY if latched Par_En=1, else STOP.
- PARITY: one cycle, TX_OUT = computed parity bit. Next state is STOP.
- STOP: one cycle, TX_OUT=1.
  - If Data_Valid=1 at the end of this cycle, the new frame is accepted and next state is START. No idle gap; Busy stays 1.
  - Otherwise next state is IDLE, with Busy=0 and TX_OUT=1 from the next cycle.
- Frame length:
  - 1+DATA_WIDTH+1 cycles without parity (10 for DATA_WIDTH=8).
  - 1+DATA_WIDTH+2 cycles with parity (11 for DATA_WIDTH=8).
- Data_Valid in START, DATA, PARITY, or STOP-without-acceptance: ignored and dropped; the frame in progress is unaffected.
- Changes to P_DATA, Par_En or Par_Typ after acceptance do not affect the frame in progress.
- Reset mid-frame: the line returns to idle immediately (TX_OUT=1, Busy=0, IDLE), asynchronously. The partial frame is abandoned and nothing is resumed after reset deasserts.
- Data_Valid asserted in the same cycle rst_n deasserts: not accepted. The first possible acceptance is on the first edge with rst_n=1.
- IDLE with no request: TX_OUT=1, Busy=0 indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Constants PAR_EVEN=0 and PAR_ODD=1.
  - Line levels LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
  - DATA_WIDTH default.
- Also used by UART_RX for consistent framing.
- One natural sub-module: uart_tx_serializer. It contains the load/shift register and the bit counter, with a done flag at DATA_WIDTH-1.
- The top module keeps the FSM, parity computation and the output mux.

Test Plan:
- Even parity: Data_Valid pulse, P_DATA=0xA5, Par_En=1, Par_Typ=0 -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1. Busy=1 for exactly those 11 cycles, then TX_OUT=1, Busy=0.
- Odd parity, no parity: same byte with Par_Typ=1 -> parity slot = 1. Same byte with Par_En=0 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1.
- Back-to-back: Data_Valid with 0x3C accepted in the stop cycle of a 0xA5 frame -> next cycle TX_OUT=0 (start). Busy never drops. Second frame carries 0x3C LSB first (0,0,1,1,1,1,0,0).
- Request while busy: Data_Valid with 0xFF pulsed during DATA of a 0x00 frame -> 0x00 frame transmitted intact, 0xFF never sent, IDLE afterwards.
- Reset mid-frame: rst_n low during data bit 4 -> TX_OUT=1 and Busy=0 asynchronously. After release, a new 0x81 request produces a clean full frame.
- Loopback: TX_OUT into UART_RX at Prescale=8 on the matching clock, 25 random bytes per parity mode -> UART_RX raises Data_Valid with P_DATA equal to each sent byte, and PAR_Err=STP_Err=0 throughout.
